// File: rtl/main_cpu.sv
// main_cpu: multi-cycle 32-bit core with an 8x32 register file. It fetches each instruction
// and performs each LD/ST data access over a four-phase request/ready handshake.
module main_cpu (
    input  logic        clk,
    input  logic        rst,
    input  logic        ExternalExchangeReady,
    inout  wire  [31:0] ExternalDataBus,
    inout  wire  [31:0] ExternalAddressBus,
    inout  wire  [31:0] InternalDataBus,
    output logic [31:0] InstructionBus,
    output logic [31:0] PCAddressBus,
    output logic [31:0] ALUAddressBus,
    output logic        GetInstruction,
    output logic [1:0]  MemIO,
    output logic        ValidMemoryData,
    output logic [2:0]  ExternalDrive,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [7:0]  ALUSel,
    output logic [23:0] DecoderData,
    output logic [2:0]  SelX,
    output logic [2:0]  SelY,
    output logic [2:0]  SelZ,
    output logic [2:0]  APSel,
    output logic [3:0]  APSet,
    output logic [2:0]  PCDrive,
    output logic [7:0]  SRSet,
    output logic        ALUrst
);

    localparam logic [7:0] OP_ADD = 8'h03;
    localparam logic [7:0] OP_SUB = 8'h04;
    localparam logic [7:0] OP_AND = 8'h05;
    localparam logic [7:0] OP_OR  = 8'h06;
    localparam logic [7:0] OP_XOR = 8'h07;
    localparam logic [7:0] OP_LDI = 8'h25;
    localparam logic [7:0] OP_LD  = 8'h26;
    localparam logic [7:0] OP_ST  = 8'h27;
    localparam logic [7:0] OP_SAP = 8'h29;

    localparam logic [1:0] MEMIO_IDLE  = 2'b00;
    localparam logic [1:0] MEMIO_READ  = 2'b01;
    localparam logic [1:0] MEMIO_WRITE = 2'b10;
    localparam logic [2:0] DRV_OFF     = 3'b000;
    localparam logic [2:0] DRV_ON      = 3'b001;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_FREL   = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_MREL   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [2:0]  ap_q, ap_d;
    logic [3:0]  sr_q, sr_d;               // {V, C, N, Z}
    logic [31:0] rf_q [8];
    logic [31:0] rf_d [8];
    logic        get_instr_q, get_instr_d;
    logic [1:0]  mem_io_q, mem_io_d;
    logic        valid_q, valid_d;
    logic [2:0]  ext_drive_q, ext_drive_d;

    logic [7:0]  opcode_s;
    logic [2:0]  sel_x_s, sel_y_s, sel_z_s;
    logic [31:0] op_a_s, op_b_s;
    logic        is_mem_s;
    logic [32:0] sum_s, diff_s;
    logic [31:0] alu_res_s;
    logic        alu_c_s, alu_v_s, alu_op_s;
    logic        wb_en_s;
    logic [2:0]  wb_sel_s;
    logic [31:0] wb_val_s;

    assign opcode_s = ir_q[7:0];
    assign sel_x_s  = ir_q[10:8];
    assign sel_y_s  = ir_q[13:11];
    assign sel_z_s  = ir_q[16:14];
    assign op_a_s   = rf_q[sel_x_s];
    assign op_b_s   = rf_q[sel_y_s];
    assign is_mem_s = (opcode_s == OP_LD) || (opcode_s == OP_ST);

    // ALU: result, carry/borrow and signed overflow for the register-register opcodes
    always_comb begin
        sum_s     = {1'b0, op_a_s} + {1'b0, op_b_s};
        diff_s    = {1'b0, op_a_s} - {1'b0, op_b_s};
        alu_res_s = 32'd0;
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        alu_op_s  = 1'b0;
        case (opcode_s)
            OP_ADD: begin
                alu_res_s = sum_s[31:0];
                alu_c_s   = sum_s[32];
                alu_v_s   = (op_a_s[31] == op_b_s[31]) && (sum_s[31] != op_a_s[31]);
                alu_op_s  = 1'b1;
            end
            OP_SUB: begin
                // bit 32 of the widened difference is the borrow
                alu_res_s = diff_s[31:0];
                alu_c_s   = diff_s[32];
                alu_v_s   = (op_a_s[31] != op_b_s[31]) && (diff_s[31] != op_a_s[31]);
                alu_op_s  = 1'b1;
            end
            OP_AND: begin
                alu_res_s = op_a_s & op_b_s;
                alu_op_s  = 1'b1;
            end
            OP_OR: begin
                alu_res_s = op_a_s | op_b_s;
                alu_op_s  = 1'b1;
            end
            OP_XOR: begin
                alu_res_s = op_a_s ^ op_b_s;
                alu_op_s  = 1'b1;
            end
            default: begin
                alu_op_s  = 1'b0;
            end
        endcase
    end

    // Writeback selection for the EXEC cycle; also what InternalDataBus carries
    always_comb begin
        wb_en_s  = 1'b0;
        wb_sel_s = 3'd0;
        wb_val_s = 32'd0;
        if ((state_q == S_EXEC) && alu_op_s) begin
            wb_en_s  = 1'b1;
            wb_sel_s = sel_z_s;
            wb_val_s = alu_res_s;
        end else if ((state_q == S_EXEC) && (opcode_s == OP_LDI)) begin
            wb_en_s  = 1'b1;
            wb_sel_s = ap_q;
            wb_val_s = {8'd0, ir_q[31:8]};
        end else begin
            wb_en_s  = 1'b0;
        end
    end

    // Next-state and next-output computation for the fetch/decode/execute/memory sequencer
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        ap_d        = ap_q;
        sr_d        = sr_q;
        rf_d        = rf_q;
        get_instr_d = 1'b0;
        mem_io_d    = MEMIO_IDLE;
        valid_d     = 1'b0;
        ext_drive_d = DRV_OFF;
        case (state_q)
            S_FETCH: begin
                // capture only once the request is visible to memory
                if (get_instr_q && ExternalExchangeReady) begin
                    ir_d    = ExternalDataBus;
                    pc_d    = pc_q + 32'd1;
                    valid_d = 1'b1;
                    state_d = S_FREL;
                end else begin
                    get_instr_d = 1'b1;
                    mem_io_d    = MEMIO_READ;
                end
            end
            S_FREL: begin
                if (!ExternalExchangeReady) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FREL;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (wb_en_s) begin
                    rf_d[wb_sel_s] = wb_val_s;
                end else begin
                    rf_d[wb_sel_s] = rf_q[wb_sel_s];
                end
                if (opcode_s == OP_SAP) begin
                    ap_d = ir_q[10:8];
                end else begin
                    ap_d = ap_q;
                end
                if (alu_op_s) begin
                    sr_d = {alu_v_s, alu_c_s, alu_res_s[31], (alu_res_s == 32'd0)};
                end else begin
                    sr_d = sr_q;
                end
                if (is_mem_s) begin
                    state_d     = S_MEM;
                    mem_io_d    = (opcode_s == OP_ST) ? MEMIO_WRITE : MEMIO_READ;
                    ext_drive_d = (opcode_s == OP_ST) ? DRV_ON : DRV_OFF;
                end else begin
                    state_d     = S_FETCH;
                    get_instr_d = 1'b1;
                    mem_io_d    = MEMIO_READ;
                end
            end
            S_MEM: begin
                ext_drive_d = ext_drive_q;
                if (ExternalExchangeReady) begin
                    if (opcode_s == OP_LD) begin
                        rf_d[sel_y_s] = ExternalDataBus;
                        valid_d       = 1'b1;
                    end else begin
                        valid_d       = 1'b0;
                    end
                    state_d = S_MREL;
                end else begin
                    mem_io_d = mem_io_q;
                end
            end
            S_MREL: begin
                // store data stays on the bus until memory drops its acknowledge
                if (!ExternalExchangeReady) begin
                    state_d     = S_FETCH;
                    get_instr_d = 1'b1;
                    mem_io_d    = MEMIO_READ;
                end else begin
                    ext_drive_d = ext_drive_q;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Core state and registered handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_FETCH;
            pc_q        <= 32'd0;
            ir_q        <= 32'd0;
            ap_q        <= 3'd0;
            sr_q        <= 4'd0;
            rf_q        <= '{default: 32'd0};
            get_instr_q <= 1'b0;
            mem_io_q    <= MEMIO_IDLE;
            valid_q     <= 1'b0;
            ext_drive_q <= DRV_OFF;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            ap_q        <= ap_d;
            sr_q        <= sr_d;
            rf_q        <= rf_d;
            get_instr_q <= get_instr_d;
            mem_io_q    <= mem_io_d;
            valid_q     <= valid_d;
            ext_drive_q <= ext_drive_d;
        end
    end

    assign ExternalDataBus    = (ext_drive_q == DRV_ON) ? op_b_s : 32'hzzzz_zzzz;
    assign ExternalAddressBus = 32'hzzzz_zzzz;
    assign InternalDataBus    = wb_en_s ? wb_val_s : 32'hzzzz_zzzz;

    assign InstructionBus  = ir_q;
    assign PCAddressBus    = pc_q;
    assign ALUAddressBus   = {29'd0, sel_x_s};
    assign GetInstruction  = get_instr_q;
    assign MemIO           = mem_io_q;
    assign ValidMemoryData = valid_q;
    assign ExternalDrive   = ext_drive_q;
    assign A               = op_a_s;
    assign B               = op_b_s;
    assign ALUSel          = opcode_s;
    assign DecoderData     = ir_q[31:8];
    assign SelX            = sel_x_s;
    assign SelY            = sel_y_s;
    assign SelZ            = sel_z_s;
    assign APSel           = ap_q;
    assign APSet           = ((state_q == S_EXEC) && (opcode_s == OP_SAP)) ? {1'b1, ir_q[10:8]} : 4'b0000;
    assign PCDrive         = {2'b00, (state_q == S_FETCH) && get_instr_q && ExternalExchangeReady};
    assign SRSet           = {4'b0000, sr_q};
    assign ALUrst          = ~rst;

endmodule

// File: tb/tb_main_cpu.sv
// Scoreboard bench for main_cpu: a memory responder feeds directed and random programs,
// an ISA-level model predicts each observable event, and a monitor checks them in order.
module tb_main_cpu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ready = 1'b0;
    logic        drv_en = 1'b0;
    logic [31:0] drv_val = 32'd0;

    wire  [31:0] ExternalDataBus;
    wire  [31:0] ExternalAddressBus;
    wire  [31:0] InternalDataBus;
    logic [31:0] InstructionBus, PCAddressBus, ALUAddressBus, A, B;
    logic        GetInstruction, ValidMemoryData, ALUrst;
    logic [1:0]  MemIO;
    logic [2:0]  ExternalDrive, SelX, SelY, SelZ, APSel, PCDrive;
    logic [7:0]  ALUSel, SRSet;
    logic [23:0] DecoderData;
    logic [3:0]  APSet;

    assign ExternalDataBus = drv_en ? drv_val : 32'hzzzz_zzzz;

    main_cpu dut (
        .clk(clk), .rst(rst), .ExternalExchangeReady(ready),
        .ExternalDataBus(ExternalDataBus), .ExternalAddressBus(ExternalAddressBus),
        .InternalDataBus(InternalDataBus), .InstructionBus(InstructionBus),
        .PCAddressBus(PCAddressBus), .ALUAddressBus(ALUAddressBus),
        .GetInstruction(GetInstruction), .MemIO(MemIO), .ValidMemoryData(ValidMemoryData),
        .ExternalDrive(ExternalDrive), .A(A), .B(B), .ALUSel(ALUSel), .DecoderData(DecoderData),
        .SelX(SelX), .SelY(SelY), .SelZ(SelZ), .APSel(APSel), .APSet(APSet),
        .PCDrive(PCDrive), .SRSet(SRSet), .ALUrst(ALUrst)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;   // 0 fetch, 1 load data, 2 store
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sr;
        logic [2:0]  ap;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic        mon_en = 1'b0;
    logic [1:0]  prev_memio = 2'b00;

    // architectural reference state
    logic [31:0] m_r [8];
    logic [31:0] m_mem [8];
    logic [2:0]  m_ap;
    logic [3:0]  m_sr;
    logic [31:0] m_pc;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;
    localparam longint UMAX = 64'sd4294967295;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input string what);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    // Execute one instruction on the reference model and queue the events it must produce.
    task automatic model_issue(input logic [31:0] ir, output logic [31:0] ld_val);
        exp_t        e;
        logic [2:0]  x, y, z;
        logic [31:0] a, b, res;
        longint      ua, ub, sa, sb, u, s;
        logic        c, v, upd;
        x = ir[10:8]; y = ir[13:11]; z = ir[16:14];
        a = m_r[x]; b = m_r[y];
        ua = longint'(a); ub = longint'(b);
        sa = longint'($signed(a)); sb = longint'($signed(b));
        m_pc = m_pc + 32'd1;
        ld_val = 32'd0;
        e = '0;
        e.kind = 2'd0; e.ir = ir; e.pc = m_pc; e.a = a; e.b = b; e.sr = m_sr; e.ap = m_ap;
        sbq.push_back(e);
        res = 32'd0; c = 1'b0; v = 1'b0; upd = 1'b0;
        case (ir[7:0])
            8'h25: m_r[m_ap] = {8'd0, ir[31:8]};
            8'h29: m_ap = x;
            8'h03: begin u = ua + ub; s = sa + sb; res = u[31:0]; c = (u > UMAX); v = (s > SMAX) || (s < SMIN); upd = 1'b1; end
            8'h04: begin u = ua - ub; s = sa - sb; res = u[31:0]; c = (ua < ub); v = (s > SMAX) || (s < SMIN); upd = 1'b1; end
            8'h05: begin res = a & b; upd = 1'b1; end
            8'h06: begin res = a | b; upd = 1'b1; end
            8'h07: begin res = a ^ b; upd = 1'b1; end
            8'h26: begin
                ld_val = m_mem[x]; m_r[y] = ld_val;
                e.kind = 2'd1; e.b = ld_val; sbq.push_back(e);
            end
            8'h27: begin
                m_mem[x] = b;
                e.kind = 2'd2; e.addr = {29'd0, x}; e.data = b; sbq.push_back(e);
            end
            default: ;
        endcase
        if (upd) begin
            m_r[z] = res;
            m_sr = {v, c, res[31], (res == 32'd0)};
        end
    endtask

    task automatic pop_check(input logic is_st);
        exp_t e;
        if (sbq.size() == 0) begin
            fail("sb_underflow", "DUT event with no pending expectation");
        end else begin
            e = sbq.pop_front();
            if (is_st) begin
                chk("st_event_kind", {30'd0, e.kind}, 32'd2);
                chk("st_addr", ALUAddressBus, e.addr);
                chk("st_data", ExternalDataBus, e.data);
                chk("st_drive", {29'd0, ExternalDrive}, 32'd1);
            end else if (e.kind == 2'd0) begin
                chk("fetch_ir", InstructionBus, e.ir);
                chk("fetch_pc", PCAddressBus, e.pc);
                chk("operand_a", A, e.a);
                chk("operand_b", B, e.b);
                chk("status", {24'd0, SRSet}, {28'd0, e.sr});
                chk("ap", {29'd0, APSel}, {29'd0, e.ap});
            end else if (e.kind == 2'd1) begin
                chk("ld_value", B, e.b);
            end else begin
                fail("valid_event_kind", "ValidMemoryData pulsed where a store was expected");
            end
        end
    endtask

    // Monitor: every ValidMemoryData pulse and every store start consumes one expectation
    always @(negedge clk) begin
        if (mon_en) begin
            if (ValidMemoryData) pop_check(1'b0);
            if ((MemIO == 2'b10) && (prev_memio != 2'b10)) pop_check(1'b1);
        end
        prev_memio <= MemIO;
    end

    // Memory responder for one instruction: fetch handshake, then the data phase if any.
    task automatic do_instr(input logic [31:0] ir, input int dly, input int hold);
        logic [31:0] ld_val;
        logic [7:0]  op;
        op = ir[7:0];
        @(negedge clk);
        for (int i = 0; i < 100 && GetInstruction !== 1'b1; i++) @(negedge clk);
        if (GetInstruction !== 1'b1) fail("fetch_timeout", "GetInstruction never rose");
        model_issue(ir, ld_val);
        repeat (dly) @(negedge clk);
        drv_val = ir; drv_en = 1'b1; ready = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("no_refetch", {31'd0, GetInstruction}, 32'd0);
        end
        ready = 1'b0; drv_en = 1'b0;
        if (op == 8'h26 || op == 8'h27) begin
            for (int i = 0; i < 100 && !(MemIO != 2'b00 && GetInstruction == 1'b0); i++) @(negedge clk);
            if (!(MemIO != 2'b00 && GetInstruction == 1'b0)) fail("mem_timeout", "no data request");
            chk("mem_dir", {30'd0, MemIO}, (op == 8'h27) ? 32'd2 : 32'd1);
            repeat (dly) @(negedge clk);
            if (op == 8'h26) begin
                drv_val = ld_val; drv_en = 1'b1;
            end
            ready = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (op == 8'h27) chk("st_drive_held", {29'd0, ExternalDrive}, 32'd1);
            end
            ready = 1'b0; drv_en = 1'b0;
            if (op == 8'h27) begin
                @(negedge clk);
                chk("st_drive_released", {29'd0, ExternalDrive}, 32'd0);
            end
        end
    endtask

    function automatic logic [31:0] rand_ir();
        logic [7:0] op;
        case ($urandom_range(0, 9))
            0: op = 8'h25;
            1: op = 8'h29;
            2: op = 8'h03;
            3: op = 8'h04;
            4: op = 8'h05;
            5: op = 8'h06;
            6: op = 8'h07;
            7: op = 8'h26;
            8: op = 8'h27;
            default: begin
                op = 8'($urandom_range(8, 255));
                if (op == 8'h25 || op == 8'h26 || op == 8'h27 || op == 8'h29) op = 8'h80;
            end
        endcase
        return {24'($urandom()), op};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] directed [8];
        directed = '{32'd3365, 32'd297, 32'd2597, 32'd34819, 32'd53764, 32'd5159, 32'h0000_00FF, 32'd11302};
        for (int i = 0; i < 8; i++) begin
            m_r[i] = 32'd0;
            m_mem[i] = $urandom();
        end
        m_ap = 3'd0; m_sr = 4'd0; m_pc = 32'd0;

        repeat (3) @(negedge clk);
        chk("rst_getinstr", {31'd0, GetInstruction}, 32'd0);
        chk("rst_memio", {30'd0, MemIO}, 32'd0);
        chk("rst_drive", {29'd0, ExternalDrive}, 32'd0);
        chk("rst_pc", PCAddressBus, 32'd0);
        chk("rst_ir", InstructionBus, 32'd0);
        chk("rst_alurst", {31'd0, ALUrst}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_getinstr", {31'd0, GetInstruction}, 32'd1);
        chk("post_rst_pc", PCAddressBus, 32'd0);
        mon_en = 1'b1;

        // LDI 13, SAP 1, LDI 10, ADD 0,1,2, SUB 3<-2-2, ST 4,2, NOP 0xFF, LD 5<-mem[4]
        for (int i = 0; i < 8; i++) do_instr(directed[i], (i == 0) ? 0 : 1, 2);
        for (int n = 0; n < 150; n++) do_instr(rand_ir(), int'($urandom_range(0, 2)), int'($urandom_range(1, 3)));
        do_instr(32'h0000_00FF, 0, 1);

        for (int i = 0; i < 100 && GetInstruction !== 1'b1; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        mon_en = 1'b0;

        // asynchronous reset in the middle of a fetch handshake
        drv_val = $urandom(); drv_en = 1'b1; ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_getinstr", {31'd0, GetInstruction}, 32'd0);
        chk("mid_rst_memio", {30'd0, MemIO}, 32'd0);
        chk("mid_rst_valid", {31'd0, ValidMemoryData}, 32'd0);
        chk("mid_rst_drive", {29'd0, ExternalDrive}, 32'd0);
        chk("mid_rst_pc", PCAddressBus, 32'd0);
        chk("mid_rst_ir", InstructionBus, 32'd0);
        chk("mid_rst_sr", {24'd0, SRSet}, 32'd0);
        chk("mid_rst_ap", {29'd0, APSel}, 32'd0);
        chk("mid_rst_a", A, 32'd0);
        chk("mid_rst_pcdrive", {29'd0, PCDrive}, 32'd0);
        ready = 1'b0; drv_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rerst_getinstr", {31'd0, GetInstruction}, 32'd1);
        chk("rerst_pc", PCAddressBus, 32'd0);
        chk("rerst_memio", {30'd0, MemIO}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
